ps2_ascii_decoder: RTL and testbench



---
 rtl/ps2_ascii_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
//   Converts PS/2 set-2 scan-code bytes into a held 7-bit uppercase ASCII
//   key value for the store address counter. Break (F0) and extended (E0)
//   prefixes are tracked by a small FSM. Extended keys never touch the
//   outputs. If the same mapped make code arrives again while its key is
//   held, it is treated as a typematic repeat and ignored.
//
//   Optional feature macro: PREFIX_TIMEOUT_EN
//     When defined, a pending prefix is abandoned after TIMEOUT_CYCLES
//     clocks with no new byte. The FSM returns to IDLE and the outputs
//     are left unchanged.
module ps2_ascii_decoder #(
    parameter logic [6:0]  IDLE_ASCII     = 7'd32,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [6:0] ascii,
    output logic       key_down,
    output logic       new_key,
    output logic       bad_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    state_t     state;
    state_t     state_next;
    logic [7:0] held;
    logic [7:0] held_next;
    logic [6:0] ascii_next;
    logic       key_down_next;
    logic       new_key_next;
    logic       bad_code_next;
    logic       map_hit;
    logic [6:0] map_ascii;
    logic       timed_out;

    // Scan-code ROM: returns {hit, ascii}. Unmapped codes return hit=0.
    function automatic logic [7:0] map_code(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h1C: r = {1'b1, 7'h41}; // A
            8'h32: r = {1'b1, 7'h42}; // B
            8'h21: r = {1'b1, 7'h43}; // C
            8'h23: r = {1'b1, 7'h44}; // D
            8'h24: r = {1'b1, 7'h45}; // E
            8'h2B: r = {1'b1, 7'h46}; // F
            8'h34: r = {1'b1, 7'h47}; // G
            8'h33: r = {1'b1, 7'h48}; // H
            8'h43: r = {1'b1, 7'h49}; // I
            8'h3B: r = {1'b1, 7'h4A}; // J
            8'h42: r = {1'b1, 7'h4B}; // K
            8'h4B: r = {1'b1, 7'h4C}; // L
            8'h3A: r = {1'b1, 7'h4D}; // M
            8'h31: r = {1'b1, 7'h4E}; // N
            8'h44: r = {1'b1, 7'h4F}; // O
            8'h4D: r = {1'b1, 7'h50}; // P
            8'h15: r = {1'b1, 7'h51}; // Q
            8'h2D: r = {1'b1, 7'h52}; // R
            8'h1B: r = {1'b1, 7'h53}; // S
            8'h2C: r = {1'b1, 7'h54}; // T
            8'h3C: r = {1'b1, 7'h55}; // U
            8'h2A: r = {1'b1, 7'h56}; // V
            8'h1D: r = {1'b1, 7'h57}; // W
            8'h22: r = {1'b1, 7'h58}; // X
            8'h35: r = {1'b1, 7'h59}; // Y
            8'h1A: r = {1'b1, 7'h5A}; // Z
            8'h45: r = {1'b1, 7'h30}; // 0
            8'h16: r = {1'b1, 7'h31}; // 1
            8'h1E: r = {1'b1, 7'h32}; // 2
            8'h26: r = {1'b1, 7'h33}; // 3
            8'h25: r = {1'b1, 7'h34}; // 4
            8'h2E: r = {1'b1, 7'h35}; // 5
            8'h36: r = {1'b1, 7'h36}; // 6
            8'h3D: r = {1'b1, 7'h37}; // 7
            8'h3E: r = {1'b1, 7'h38}; // 8
            8'h46: r = {1'b1, 7'h39}; // 9
            8'h29: r = {1'b1, 7'd32}; // space
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Combinational lookup of the incoming byte.
    always_comb begin
        {map_hit, map_ascii} = map_code(scan_code);
    end

`ifdef PREFIX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] prefix_cnt;

    assign timed_out = (state != IDLE) && !scan_valid && (prefix_cnt == CNT_LAST);

    // Prefix watchdog: counts idle cycles while a prefix is pending, and
    // clears on any byte or once back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefix_cnt <= '0;
        end else if (scan_valid || state == IDLE || timed_out) begin
            prefix_cnt <= '0;
        end else begin
            prefix_cnt <= prefix_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // Next-state and next-output decode for the prefix FSM.
    always_comb begin
        state_next    = state;
        held_next     = held;
        ascii_next    = ascii;
        key_down_next = key_down;
        new_key_next  = 1'b0;
        bad_code_next = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == CODE_BREAK) begin
                        state_next = BRK;
                    end else if (scan_code == CODE_EXT) begin
                        state_next = EXT;
                    end else if (map_hit) begin
                        // Repeats of the held key are typematic and do nothing.
                        if (!(key_down && scan_code == held)) begin
                            ascii_next    = map_ascii;
                            held_next     = scan_code;
                            key_down_next = 1'b1;
                            new_key_next  = 1'b1;
                        end
                    end else begin
                        bad_code_next = 1'b1;
                    end
                end
                BRK: begin
                    // Only releasing the held key clears the output; a
                    // release of an overridden key is silently ignored.
                    if (key_down && scan_code == held) begin
                        ascii_next    = IDLE_ASCII;
                        key_down_next = 1'b0;
                    end
                    state_next = IDLE;
                end
                EXT: begin
                    state_next = (scan_code == CODE_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else if (timed_out) begin
            state_next = IDLE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            held     <= 8'h00;
            ascii    <= IDLE_ASCII;
            key_down <= 1'b0;
            new_key  <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            state    <= state_next;
            held     <= held_next;
            ascii    <= ascii_next;
            key_down <= key_down_next;
            new_key  <= new_key_next;
            bad_code <= bad_code_next;
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Testbench for ps2_ascii_decoder: table-driven byte vectors plus
// hand-written reset and prefix-timeout sequences.
module tb_ps2_ascii_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [6:0] ascii;
    logic       key_down;
    logic       new_key;
    logic       bad_code;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       vld;
        logic [7:0] code;
        logic [6:0] a;
        logic       kd;
        logic       nk;
        logic       bc;
    } vec_t;

    vec_t vecs[$];

    ps2_ascii_decoder #(
        .IDLE_ASCII    (7'd32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .ascii     (ascii),
        .key_down  (key_down),
        .new_key   (new_key),
        .bad_code  (bad_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] c, input logic [6:0] a,
                       input logic kd, input logic nk, input logic bc);
        vec_t t;
        t.vld = v; t.code = c; t.a = a; t.kd = kd; t.nk = nk; t.bc = bc;
        vecs.push_back(t);
    endtask

    // Drive one byte (or idle cycle) and wait until just after the edge.
    task automatic step(input logic v, input logic [7:0] c);
        @(negedge clk);
        scan_valid = v;
        scan_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [6:0] a, input logic kd,
                             input logic nk, input logic bc);
        check({tag, " ascii"},    ascii,          a);
        check({tag, " key_down"}, {6'd0, key_down}, {6'd0, kd});
        check({tag, " new_key"},  {6'd0, new_key},  {6'd0, nk});
        check({tag, " bad_code"}, {6'd0, bad_code}, {6'd0, bc});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Table: vld, code, ascii, key_down, new_key, bad_code (after the edge).
        add(1, 8'h1C, 7'h41, 1, 1, 0); // A press, new_key pulse
        add(0, 8'h00, 7'h41, 1, 0, 0); // pulse lasts one cycle
        add(1, 8'h1C, 7'h41, 1, 0, 0); // typematic
        add(1, 8'h1C, 7'h41, 1, 0, 0); // typematic
        add(1, 8'hF0, 7'h41, 1, 0, 0);
        add(1, 8'h1C, 7'd32, 0, 0, 0); // release A
        add(1, 8'h1C, 7'h41, 1, 1, 0); // A again
        add(1, 8'h32, 7'h42, 1, 1, 0); // B overrides
        add(1, 8'hF0, 7'h42, 1, 0, 0);
        add(1, 8'h1C, 7'h42, 1, 0, 0); // release of overridden A ignored
        add(1, 8'hF0, 7'h42, 1, 0, 0);
        add(1, 8'h32, 7'd32, 0, 0, 0); // release B
        add(1, 8'h16, 7'h31, 1, 1, 0); // '1'
        add(1, 8'hE0, 7'h31, 1, 0, 0);
        add(1, 8'h75, 7'h31, 1, 0, 0); // extended make discarded
        add(1, 8'hE0, 7'h31, 1, 0, 0);
        add(1, 8'hF0, 7'h31, 1, 0, 0);
        add(1, 8'h75, 7'h31, 1, 0, 0); // extended break discarded
        add(1, 8'h05, 7'h31, 1, 0, 1); // unmapped make
        add(0, 8'h00, 7'h31, 1, 0, 0); // bad_code one cycle
        add(0, 8'h1C, 7'h31, 1, 0, 0); // scan_valid low ignored
        add(1, 8'hF0, 7'h31, 1, 0, 0);
        add(1, 8'hE0, 7'h31, 1, 0, 0); // E0 in BRK: ignored, back to IDLE
        add(1, 8'h16, 7'h31, 1, 0, 0); // now a repeat make
        add(1, 8'hE0, 7'h31, 1, 0, 0);
        add(1, 8'h16, 7'h31, 1, 0, 0); // discarded in EXT
        add(1, 8'hF0, 7'h31, 1, 0, 0);
        add(1, 8'h16, 7'd32, 0, 0, 0); // release '1'
        add(1, 8'h4D, 7'h50, 1, 1, 0); // P
        add(1, 8'h45, 7'h30, 1, 1, 0); // 0
        add(1, 8'h29, 7'd32, 1, 1, 0); // space key
        add(1, 8'h1A, 7'h5A, 1, 1, 0); // Z
        add(1, 8'h46, 7'h39, 1, 1, 0); // 9
        add(1, 8'h3B, 7'h4A, 1, 1, 0); // J
        add(1, 8'hF0, 7'h4A, 1, 0, 0);
        add(1, 8'h3B, 7'd32, 0, 0, 0); // release J

        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 7'd32, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vld, vecs[i].code);
            check_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].kd, vecs[i].nk, vecs[i].bc);
        end

        // Reset mid-sequence: pending break must be dropped, outputs clear at once.
        step(1, 8'h1C);
        check_all("rst_pre", 7'h41, 1, 1, 0);
        step(1, 8'hF0);
        @(negedge clk);
        scan_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check_all("rst_async", 7'd32, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 8'h1C);
        check_all("rst_post", 7'h41, 1, 1, 0);

        // Prefix timeout: 1C, F0, 20 idle cycles, then 1C.
        do_reset();
        step(1, 8'h1C);
        check_all("to_press", 7'h41, 1, 1, 0);
        step(1, 8'hF0);
        for (int i = 0; i < 20; i++) step(0, 8'h00);
        step(1, 8'h1C);
`ifdef PREFIX_TIMEOUT_EN
        check_all("to_after", 7'h41, 1, 0, 0);
`else
        check_all("to_after", 7'd32, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
